cache_request_arbiter: RTL and testbench
========================================

CACHE_REQUEST_ARBITER -- requirements
Module: cache_request_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_SIZE, 32, address width.
- DATA_SIZE, 32, data width.
- BVAL_SIZE, 4, byte-valid width.
- P_TIMEOUT, 64, maximum ISSUE cycles (used only with TIMEOUT_EN).
REQ-002 SHALL have ports, one per line:
- CACHE_CLK  in  1  single clock; all logic on its rising edge.
- CACHE_RESET_N  in  1  asynchronous, active-low reset.
- REQ0_ADDR / REQ1_ADDR  in  ADDR_SIZE  requester address.
- REQ0_WR / REQ1_WR  in  1  write request level.
- REQ0_RD / REQ1_RD  in  1  read request level.
- REQ0_OUT_DATA / REQ1_OUT_DATA  in  DATA_SIZE  write data.
- REQ0_BVAL / REQ1_BVAL  in  BVAL_SIZE  byte valids.
- REQ0_IN_DATA / REQ1_IN_DATA  out  DATA_SIZE  read data returned.
- REQ0_ACK / REQ1_ACK  out  1  one-cycle completion pulse.
- REQ0_ERR / REQ1_ERR  out  1  timeout flag, valid with ACK.
- CACHE_ADDR, CACHE_WR, CACHE_RD, CACHE_IN_DATA, CACHE_BVAL  out  as REQx  registered cache command.
- CACHE_OUT_DATA  in  DATA_SIZE  cache read data.
- CACHE_ACK  in  1  cache completion.
- BUSY  out  1  high when the state is not IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE and RESP; all outputs SHALL be registered.
REQ-004 A requester is pending when its RD=1 or WR=1, sampled at a rising edge.
REQ-005 In IDLE with one requester pending, SHALL grant it.
REQ-006 In IDLE with both pending, SHALL grant the requester not recorded in LAST_GRANT (round-robin), then update LAST_GRANT.
REQ-007 On grant, SHALL load CACHE_ADDR, CACHE_IN_DATA and CACHE_BVAL from the winner and go to ISSUE.
- CACHE_WR and CACHE_RD SHALL go high one cycle after the request is sampled.
REQ-008 If the winner has both WR=1 and RD=1, SHALL issue a write only (CACHE_RD=0).
REQ-009 In ISSUE, SHALL hold all CACHE_* outputs stable until CACHE_ACK=1 is sampled.
REQ-010 On CACHE_ACK=1 in ISSUE:
- clear CACHE_WR and CACHE_RD;
- copy CACHE_OUT_DATA to the granted REQx_IN_DATA (read transactions only; writes leave IN_DATA unchanged);
- assert the granted REQx_ACK for exactly one cycle;
- go to RESP.
REQ-011 RESP SHALL last exactly one cycle, then return to IDLE.
- A requester SHALL deassert RD/WR on the edge at which it samples ACK=1.
- The minimum back-to-back spacing is 3 cycles per transaction.
REQ-012 The non-granted requester SHALL wait with no ACK; its inputs SHALL be sampled only at grant.
REQ-013 CACHE_ACK sampled in IDLE or RESP SHALL be ignored.
REQ-014 REQx_IN_DATA SHALL hold its last value between transactions.
REQ-015 REQx_ERR SHALL be 0 except as specified in REQ-020.

Reset
REQ-016 CACHE_RESET_N=0 SHALL asynchronously force:
- state to IDLE and LAST_GRANT to 1 (REQ0 wins the first tie);
- all CACHE_* outputs, REQx_IN_DATA, REQx_ACK, REQx_ERR and BUSY to 0.
REQ-017 Reset during ISSUE or RESP SHALL abandon the transaction with no ACK to any requester.
REQ-018 The first grant SHALL occur no earlier than the first rising edge after reset release.

Configuration
REQ-019 Macro CACHE_ARB_TIMEOUT_EN SHALL enable a watchdog counter that runs in ISSUE.
REQ-020 With CACHE_ARB_TIMEOUT_EN defined, if CACHE_ACK has not arrived after P_TIMEOUT ISSUE cycles:
- clear CACHE_WR and CACHE_RD;
- pulse the granted ACK with ERR=1 and IN_DATA=0;
- go to RESP.
A CACHE_ACK arriving in the same cycle as the timeout SHALL take precedence (ERR=0).
REQ-021 Without CACHE_ARB_TIMEOUT_EN, no counter SHALL exist, ISSUE SHALL wait indefinitely, and REQx_ERR SHALL be tied to 0.

Verification
REQ-022 Single read scenario:
- stimulus: REQ0_RD=1, ADDR=0x10; cache acks 2 cycles later with 0xDEADBEEF;
- response: CACHE_RD high one cycle after the request; REQ0_IN_DATA=0xDEADBEEF; one REQ0_ACK pulse; REQ1 untouched.
REQ-023 Simultaneous requests scenario:
- stimulus: REQ0_WR and REQ1_RD asserted at the same edge after reset;
- response: REQ0 served first; REQ1 served next; REQ1 wins the following tie.
REQ-024 RD+WR scenario:
- stimulus: REQ1_WR=1 and REQ1_RD=1 with BVAL=4'b0011;
- response: CACHE_WR=1, CACHE_RD=0, CACHE_BVAL=4'b0011.
REQ-025 Reset mid-ISSUE scenario:
- stimulus: drop CACHE_RESET_N while CACHE_RD=1;
- response: all outputs 0 immediately; no ACK afterwards even if CACHE_ACK arrives.
REQ-026 Timeout scenario (CACHE_ARB_TIMEOUT_EN, P_TIMEOUT=8):
- stimulus: CACHE_ACK never asserted;
- response: after 8 ISSUE cycles, REQ0_ACK=1, REQ0_ERR=1, REQ0_IN_DATA=0.
- Without the macro: BUSY remains 1.

Source files
------------

// File: rtl/cache_request_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_request_arbiter_if
//
// Purpose:
//   Bundles every signal between two cache requesters, the arbiter and the
//   cache into one interface. Clock and reset are not part of the bundle.
//
// Signal summary:
//   REQx_ADDR, REQx_WR, REQx_RD, REQx_OUT_DATA, REQx_BVAL  requester -> arbiter
//   REQx_IN_DATA, REQx_ACK, REQx_ERR                       arbiter -> requester
//   CACHE_ADDR, CACHE_WR, CACHE_RD, CACHE_IN_DATA,
//   CACHE_BVAL                                             arbiter -> cache
//   CACHE_OUT_DATA, CACHE_ACK                              cache -> arbiter
//   BUSY                                                   arbiter status
//
// Modports:
//   slave  : the arbiter (serves requests, drives the cache command)
//   master : the environment (requesters plus cache model)
// -----------------------------------------------------------------------------
interface cache_request_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int BVAL_SIZE = 4
);

  // requester 0
  logic [ADDR_SIZE-1:0] REQ0_ADDR;
  logic                 REQ0_WR;
  logic                 REQ0_RD;
  logic [DATA_SIZE-1:0] REQ0_OUT_DATA;
  logic [BVAL_SIZE-1:0] REQ0_BVAL;
  logic [DATA_SIZE-1:0] REQ0_IN_DATA;
  logic                 REQ0_ACK;
  logic                 REQ0_ERR;

  // requester 1
  logic [ADDR_SIZE-1:0] REQ1_ADDR;
  logic                 REQ1_WR;
  logic                 REQ1_RD;
  logic [DATA_SIZE-1:0] REQ1_OUT_DATA;
  logic [BVAL_SIZE-1:0] REQ1_BVAL;
  logic [DATA_SIZE-1:0] REQ1_IN_DATA;
  logic                 REQ1_ACK;
  logic                 REQ1_ERR;

  // cache side
  logic [ADDR_SIZE-1:0] CACHE_ADDR;
  logic                 CACHE_WR;
  logic                 CACHE_RD;
  logic [DATA_SIZE-1:0] CACHE_IN_DATA;
  logic [BVAL_SIZE-1:0] CACHE_BVAL;
  logic [DATA_SIZE-1:0] CACHE_OUT_DATA;
  logic                 CACHE_ACK;

  // status
  logic                 BUSY;

  modport slave (
    input  REQ0_ADDR, REQ0_WR, REQ0_RD, REQ0_OUT_DATA, REQ0_BVAL,
    output REQ0_IN_DATA, REQ0_ACK, REQ0_ERR,
    input  REQ1_ADDR, REQ1_WR, REQ1_RD, REQ1_OUT_DATA, REQ1_BVAL,
    output REQ1_IN_DATA, REQ1_ACK, REQ1_ERR,
    output CACHE_ADDR, CACHE_WR, CACHE_RD, CACHE_IN_DATA, CACHE_BVAL,
    input  CACHE_OUT_DATA, CACHE_ACK,
    output BUSY
  );

  modport master (
    output REQ0_ADDR, REQ0_WR, REQ0_RD, REQ0_OUT_DATA, REQ0_BVAL,
    input  REQ0_IN_DATA, REQ0_ACK, REQ0_ERR,
    output REQ1_ADDR, REQ1_WR, REQ1_RD, REQ1_OUT_DATA, REQ1_BVAL,
    input  REQ1_IN_DATA, REQ1_ACK, REQ1_ERR,
    input  CACHE_ADDR, CACHE_WR, CACHE_RD, CACHE_IN_DATA, CACHE_BVAL,
    output CACHE_OUT_DATA, CACHE_ACK,
    input  BUSY
  );

endinterface

// File: rtl/cache_request_arbiter.sv
// -----------------------------------------------------------------------------
// cache_request_arbiter
//
// Purpose:
//   Two-requester arbiter in front of a single cache port. A pending
//   requester (RD or WR high) is granted from IDLE; on a tie the requester
//   that did not win the previous tie is chosen. The granted command is
//   registered onto the cache port and held in ISSUE until the cache acks,
//   then the requester gets a one-cycle ACK (with read data for reads) and
//   the arbiter spends one RESP cycle before returning to IDLE.
//   Every output is driven straight from a flop.
//
// Ports:
//   CACHE_CLK      in   clock, rising edge
//   CACHE_RESET_N  in   asynchronous active-low reset
//   bus            slave modport of cache_request_arbiter_if carrying the
//                  REQ0/REQ1 requester buses, the CACHE_* command/response
//                  and BUSY
//
// Configuration:
//   CACHE_ARB_TIMEOUT_EN  when defined, a watchdog counts ISSUE cycles and
//                         terminates the transaction after P_TIMEOUT cycles
//                         with ERR=1 and IN_DATA=0. When undefined, ISSUE
//                         waits forever and both ERR outputs are tied low.
// -----------------------------------------------------------------------------
module cache_request_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int BVAL_SIZE = 4,
  parameter int P_TIMEOUT = 64
) (
  input  logic                    CACHE_CLK,
  input  logic                    CACHE_RESET_N,
  cache_request_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Requester index that won the most recent tie. Resets to 1 so that
  // requester 0 wins the first tie.
  logic last_grant_reg, last_grant_next;
  // Requester currently being served.
  logic grant_reg, grant_next;

  logic [ADDR_SIZE-1:0] cache_addr_reg, cache_addr_next;
  logic [DATA_SIZE-1:0] cache_in_data_reg, cache_in_data_next;
  logic [BVAL_SIZE-1:0] cache_bval_reg, cache_bval_next;
  logic                 cache_wr_reg, cache_wr_next;
  logic                 cache_rd_reg, cache_rd_next;

  logic [DATA_SIZE-1:0] in_data_reg  [2];
  logic [DATA_SIZE-1:0] in_data_next [2];
  logic [1:0]           ack_reg, ack_next;
  logic                 busy_reg;

  // Requester buses viewed as small arrays so the winner can be indexed.
  logic [ADDR_SIZE-1:0] req_addr  [2];
  logic [DATA_SIZE-1:0] req_wdata [2];
  logic [BVAL_SIZE-1:0] req_bval  [2];
  logic [1:0]           req_wr;
  logic [1:0]           req_rd;
  logic [1:0]           pending;
  logic                 winner;

  assign req_addr[0]  = bus.REQ0_ADDR;
  assign req_addr[1]  = bus.REQ1_ADDR;
  assign req_wdata[0] = bus.REQ0_OUT_DATA;
  assign req_wdata[1] = bus.REQ1_OUT_DATA;
  assign req_bval[0]  = bus.REQ0_BVAL;
  assign req_bval[1]  = bus.REQ1_BVAL;
  assign req_wr       = {bus.REQ1_WR, bus.REQ0_WR};
  assign req_rd       = {bus.REQ1_RD, bus.REQ0_RD};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pending
      assign pending[gi] = req_rd[gi] | req_wr[gi];
    end
  endgenerate

`ifdef CACHE_ARB_TIMEOUT_EN
  // Counts completed ISSUE cycles; the transaction is abandoned on the
  // P_TIMEOUT-th ISSUE edge that sees no CACHE_ACK.
  localparam int CNT_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             timeout;
  logic [1:0]       err_reg, err_next;

  assign timeout = (wd_cnt_reg == CNT_W'(P_TIMEOUT - 1));
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CACHE_CLK or negedge CACHE_RESET_N) begin
    if (!CACHE_RESET_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    last_grant_next    = last_grant_reg;
    grant_next         = grant_reg;
    cache_addr_next    = cache_addr_reg;
    cache_in_data_next = cache_in_data_reg;
    cache_bval_next    = cache_bval_reg;
    cache_wr_next      = cache_wr_reg;
    cache_rd_next      = cache_rd_reg;
    in_data_next       = in_data_reg;
    ack_next           = 2'b00;
    winner             = 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
    wd_cnt_next        = wd_cnt_reg;
    err_next           = 2'b00;
`endif

    case (state_reg)
      IDLE: begin
        if (pending != 2'b00) begin
          // Round-robin memory only moves on a real tie; a lone requester
          // is granted without disturbing the tie order.
          if (pending == 2'b11) begin
            winner          = ~last_grant_reg;
            last_grant_next = ~last_grant_reg;
          end else begin
            winner = pending[1];
          end

          grant_next         = winner;
          cache_addr_next    = req_addr[winner];
          cache_in_data_next = req_wdata[winner];
          cache_bval_next    = req_bval[winner];
          // A request with both WR and RD is issued as a write only.
          cache_wr_next      = req_wr[winner];
          cache_rd_next      = req_rd[winner] & ~req_wr[winner];
`ifdef CACHE_ARB_TIMEOUT_EN
          wd_cnt_next        = '0;
`endif
          state_next         = ISSUE;
        end
      end

      ISSUE: begin
        // CACHE_ACK is checked first so that it wins over a simultaneous
        // timeout.
        if (bus.CACHE_ACK) begin
          cache_wr_next = 1'b0;
          cache_rd_next = 1'b0;
          if (cache_rd_reg) begin
            in_data_next[grant_reg] = bus.CACHE_OUT_DATA;
          end
          ack_next[grant_reg] = 1'b1;
          state_next          = RESP;
        end
`ifdef CACHE_ARB_TIMEOUT_EN
        else if (timeout) begin
          cache_wr_next           = 1'b0;
          cache_rd_next           = 1'b0;
          in_data_next[grant_reg] = '0;
          ack_next[grant_reg]     = 1'b1;
          err_next[grant_reg]     = 1'b1;
          state_next              = RESP;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
`endif
      end

      RESP: begin
        // ACK drops here (ack_next defaults low); any CACHE_ACK is ignored.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and cache-command registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CACHE_CLK or negedge CACHE_RESET_N) begin
    if (!CACHE_RESET_N) begin
      last_grant_reg    <= 1'b1;
      grant_reg         <= 1'b0;
      cache_addr_reg    <= '0;
      cache_in_data_reg <= '0;
      cache_bval_reg    <= '0;
      cache_wr_reg      <= 1'b0;
      cache_rd_reg      <= 1'b0;
      ack_reg           <= 2'b00;
      busy_reg          <= 1'b0;
    end else begin
      last_grant_reg    <= last_grant_next;
      grant_reg         <= grant_next;
      cache_addr_reg    <= cache_addr_next;
      cache_in_data_reg <= cache_in_data_next;
      cache_bval_reg    <= cache_bval_next;
      cache_wr_reg      <= cache_wr_next;
      cache_rd_reg      <= cache_rd_next;
      ack_reg           <= ack_next;
      // Registered copy of "state is not IDLE", aligned with state_reg.
      busy_reg          <= (state_next != IDLE);
    end
  end

  // Per-requester read-data holding registers.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in_data
      always_ff @(posedge CACHE_CLK or negedge CACHE_RESET_N) begin
        if (!CACHE_RESET_N) begin
          in_data_reg[gi] <= '0;
        end else begin
          in_data_reg[gi] <= in_data_next[gi];
        end
      end
    end
  endgenerate

`ifdef CACHE_ARB_TIMEOUT_EN
  always_ff @(posedge CACHE_CLK or negedge CACHE_RESET_N) begin
    if (!CACHE_RESET_N) begin
      wd_cnt_reg <= '0;
      err_reg    <= 2'b00;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
      err_reg    <= err_next;
    end
  end

  assign bus.REQ0_ERR = err_reg[0];
  assign bus.REQ1_ERR = err_reg[1];
`else
  assign bus.REQ0_ERR = 1'b0;
  assign bus.REQ1_ERR = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.REQ0_IN_DATA  = in_data_reg[0];
  assign bus.REQ1_IN_DATA  = in_data_reg[1];
  assign bus.REQ0_ACK      = ack_reg[0];
  assign bus.REQ1_ACK      = ack_reg[1];

  assign bus.CACHE_ADDR    = cache_addr_reg;
  assign bus.CACHE_WR      = cache_wr_reg;
  assign bus.CACHE_RD      = cache_rd_reg;
  assign bus.CACHE_IN_DATA = cache_in_data_reg;
  assign bus.CACHE_BVAL    = cache_bval_reg;

  assign bus.BUSY          = busy_reg;

endmodule

// File: tb/tb_cache_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_request_arbiter
//
// Two random requester agents and a random-latency cache model drive the
// arbiter. A transaction-level model decides, from the set of requesters
// waiting when a command appears, who should have won (round-robin on ties)
// and what the cache command and the returned data must be. Expected
// responses are queued and a separate monitor compares them when ACK fires.
// Directed tail: grant latency, stall (or watchdog timeout when
// CACHE_ARB_TIMEOUT_EN is defined), and reset in the middle of ISSUE.
// -----------------------------------------------------------------------------
module tb_cache_request_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int PT    = 64;
  localparam int N_TXN = 60;

  logic clk;
  logic rst_n;

  cache_request_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BVAL_SIZE(BW)) bus ();

  cache_request_arbiter #(
    .ADDR_SIZE(AW),
    .DATA_SIZE(DW),
    .BVAL_SIZE(BW),
    .P_TIMEOUT(PT)
  ) dut (
    .CACHE_CLK    (clk),
    .CACHE_RESET_N(rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  logic [DW-1:0] hold [2];
  int n_acks = 0;

  bit rand_en = 1'b0;
  bit resp_en = 1'b1;
  int dir_req_cnt = 0;

  // requester agent state
  bit            active  [2];
  logic          r_rd    [2];
  logic          r_wr    [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];
  logic [BW-1:0] r_bval  [2];

  assign bus.REQ0_RD       = r_rd[0];
  assign bus.REQ0_WR       = r_wr[0];
  assign bus.REQ0_ADDR     = r_addr[0];
  assign bus.REQ0_OUT_DATA = r_wdata[0];
  assign bus.REQ0_BVAL     = r_bval[0];
  assign bus.REQ1_RD       = r_rd[1];
  assign bus.REQ1_WR       = r_wr[1];
  assign bus.REQ1_ADDR     = r_addr[1];
  assign bus.REQ1_OUT_DATA = r_wdata[1];
  assign bus.REQ1_BVAL     = r_bval[1];

  logic resp_ack;
  logic force_ack;
  logic [DW-1:0] resp_data;
  assign bus.CACHE_ACK      = resp_ack | force_ack;
  assign bus.CACHE_OUT_DATA = resp_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Requester agents: hold a request until its ACK is seen, then drop it.
  // ---------------------------------------------------------------------------
  initial begin
    int served;
    bit seen [2];
    int kind;
    served = 0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; r_rd[i] = 1'b0; r_wr[i] = 1'b0;
      r_addr[i] = '0; r_wdata[i] = '0; r_bval[i] = '0;
    end
    forever begin
      @(negedge clk);
      seen[0] = bus.REQ0_ACK;
      seen[1] = bus.REQ1_ACK;
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          active[i] = 1'b0; r_rd[i] = 1'b0; r_wr[i] = 1'b0;
        end else if (active[i]) begin
          if (seen[i]) begin
            active[i] = 1'b0; r_rd[i] = 1'b0; r_wr[i] = 1'b0;
          end
        end else if (i == 0 && served != dir_req_cnt) begin
          served++;
          active[0] = 1'b1; r_rd[0] = 1'b1; r_wr[0] = 1'b0;
          r_addr[0] = 32'h10; r_wdata[0] = $urandom; r_bval[0] = 4'hF;
        end else if (rand_en && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 2);
          active[i]  = 1'b1;
          r_rd[i]    = (kind != 1);
          r_wr[i]    = (kind != 0);
          r_addr[i]  = $urandom;
          r_wdata[i] = $urandom;
          r_bval[i]  = BW'($urandom);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cache model + reference arbitration model. When a new command appears,
  // the set of requesters that were waiting just before the grant decides
  // the expected winner.
  // ---------------------------------------------------------------------------
  initial begin
    bit       prev_cmd, cmd, is_rd;
    bit [1:0] snap;
    bit       model_last;
    int       win, d;
    logic [DW-1:0] rdata;
    logic [AW-1:0] e_addr;
    logic [DW+BW+1:0] e_rest;
    prev_cmd = 1'b0; snap = 2'b00; model_last = 1'b1;
    resp_ack = 1'b0; force_ack = 1'b0; resp_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cmd = 1'b0; snap = 2'b00; model_last = 1'b1;
      end else begin
        cmd = bus.CACHE_WR | bus.CACHE_RD;
        if (cmd && !prev_cmd) begin
          if (snap == 2'b11) begin
            win = model_last ? 0 : 1;
            model_last = (win == 1);
          end else if (snap == 2'b10) begin
            win = 1;
          end else begin
            win = 0;
          end
          tests++;
          if (snap == 2'b00) begin
            fails++;
            $display("FAIL grant_without_request: got cmd expected none (t=%0t)", $time);
          end
          is_rd  = r_rd[win] && !r_wr[win];
          e_addr = r_addr[win];
          e_rest = {r_wdata[win], r_bval[win], r_wr[win], is_rd};
          check("cmd_addr", bus.CACHE_ADDR, e_addr);
          check("cmd_data_bval_wr_rd",
                {bus.CACHE_IN_DATA, bus.CACHE_BVAL, bus.CACHE_WR, bus.CACHE_RD}, e_rest);
          check("busy_in_issue", bus.BUSY, 1'b1);
          $display("[TB] grant req%0d %s addr=0x%08h", win,
                   r_wr[win] ? "WR" : "RD", e_addr);
          if (resp_en) begin
            d = $urandom_range(0, 4);
            repeat (d) begin
              @(negedge clk);
              check("hold_addr", bus.CACHE_ADDR, e_addr);
              check("hold_cmd",
                    {bus.CACHE_IN_DATA, bus.CACHE_BVAL, bus.CACHE_WR, bus.CACHE_RD}, e_rest);
            end
            @(posedge clk);
            #2;
            rdata     = $urandom;
            resp_data = rdata;
            resp_ack  = 1'b1;
            exp_q.push_back('{id: win, data: (is_rd ? rdata : hold[win]), err: 1'b0});
            @(posedge clk);
            #2;
            // Sometimes leave CACHE_ACK up through RESP, where it must be ignored.
            if ($urandom_range(0, 1) == 1) begin
              @(posedge clk);
              #2;
            end
            resp_ack  = 1'b0;
            resp_data = $urandom;
            cmd = 1'b0;
          end else begin
            snap = {active[1], active[0]};
          end
          prev_cmd = cmd;
        end else begin
          prev_cmd = cmd;
          snap = {active[1], active[0]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard on every ACK, checks idle outputs otherwise.
  // ---------------------------------------------------------------------------
  initial begin
    logic a, e;
    logic [DW-1:0] d;
    exp_t ex;
    hold[0] = '0;
    hold[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold[0] = '0;
        hold[1] = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          a = (i == 1) ? bus.REQ1_ACK     : bus.REQ0_ACK;
          e = (i == 1) ? bus.REQ1_ERR     : bus.REQ0_ERR;
          d = (i == 1) ? bus.REQ1_IN_DATA : bus.REQ0_IN_DATA;
          if (a) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_ack: got ack on req%0d expected none (t=%0t)", i, $time);
            end else begin
              ex = exp_q.pop_front();
              check("ack_id", 64'(i), 64'(ex.id));
              check("ack_in_data", d, ex.data);
              check("ack_err", e, ex.err);
              $display("[TB] ack req%0d data=0x%08h err=%0b", i, d, e);
              n_acks++;
            end
            hold[i] = d;
          end else begin
            check("err_without_ack", e, 1'b0);
            check("in_data_hold", d, hold[i]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed request on requester 0 (RD 0x10) with grant-latency check.
  // ---------------------------------------------------------------------------
  task automatic dir_request();
    @(posedge clk);
    #1;
    dir_req_cnt++;
    @(negedge clk);
    check("lat_not_yet", bus.CACHE_RD, 1'b0);
    @(negedge clk);
    check("lat_cache_rd", bus.CACHE_RD, 1'b1);
    check("lat_cache_wr", bus.CACHE_WR, 1'b0);
    check("lat_addr", bus.CACHE_ADDR, 32'h10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cache_cmd"}, {bus.CACHE_WR, bus.CACHE_RD, bus.BUSY}, 3'b000);
    check({tag, "_cache_addr"}, bus.CACHE_ADDR, '0);
    check({tag, "_cache_data_bval"}, {bus.CACHE_IN_DATA, bus.CACHE_BVAL}, '0);
    check({tag, "_ack_err"}, {bus.REQ0_ACK, bus.REQ1_ACK, bus.REQ0_ERR, bus.REQ1_ERR}, 4'b0000);
    check({tag, "_in_data"}, {bus.REQ0_IN_DATA, bus.REQ1_IN_DATA}, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    int k;
    int acks_before;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Random phase
    rand_en = 1'b1;
    cyc = 0;
    while (n_acks < N_TXN && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("random_phase_acks_reached", 64'(n_acks >= N_TXN), 64'(1));
    rand_en = 1'b0;

    cyc = 0;
    while ((active[0] || active[1] || bus.BUSY || exp_q.size() != 0) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_idle", {active[0], active[1], bus.BUSY}, 3'b000);
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

    // Directed: cache never answers
    resp_en = 1'b0;
    dir_request();
`ifdef CACHE_ARB_TIMEOUT_EN
    exp_q.push_back('{id: 0, data: '0, err: 1'b1});
    k = 0;
    while (!bus.REQ0_ACK && k < PT + 20) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", 64'(k), 64'(PT));
    repeat (4) @(negedge clk);
    dir_request();
`else
    k = 0;
    repeat (100) @(negedge clk);
    check("stall_busy", bus.BUSY, 1'b1);
    check("stall_cache_rd", bus.CACHE_RD, 1'b1);
`endif

    // Reset in the middle of ISSUE
    acks_before = n_acks;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_issue_reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    force_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_idle", {bus.BUSY, bus.CACHE_RD, bus.CACHE_WR}, 3'b000);
    check("post_reset_no_ack", 64'(n_acks), 64'(acks_before));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
